gb_timer: RTL

- DIV/TIMA/TMA/TAC timer block (FF04-FF07).
- Sits directly upstream of the interrupt controller; drives its timer_int input.
- Advances only on cpu_en, the same M-cycle enable the interrupt controller uses, so every raised interrupt is sampled exactly once.
- Implements the DMG falling-edge TIMA clocking and the delayed overflow reload.

---
 rtl/gb_timer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/gb_timer.sv
// gb_timer: DMG-style DIV/TIMA/TMA/TAC timer block (FF04-FF07).
//
// A 16-bit system counter advances by 4 T-cycles on every cpu_en (M-cycle)
// enable. DIV exposes its upper byte. TIMA is clocked on the falling edge of
// (TAC.enable & sys_cnt[tap]), and an overflow passes through a one-M-cycle
// OVF window (TIMA reads 00, a TIMA write cancels the reload) and a
// one-M-cycle RELOAD window (TIMA writes ignored, TMA writes fall through to
// TIMA). timer_int is raised for exactly one cpu_en window per overflow.
//
// Optional feature macro: GB_TIMER_GLITCH_EN
//   defined   : a DIV or TAC write that drops the tap select from 1 to 0
//               clocks TIMA in that cycle (DMG glitch behaviour).
//   undefined : any cpu_en cycle with a DIV or TAC write never clocks TIMA.
//
// Parameters:
//   DIV_INIT  reset value of the internal 16-bit system counter
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   cpu_en     one-cycle M-cycle enable qualifying every state update
//   addr       register select: 0 DIV, 1 TIMA, 2 TMA, 3 TAC
//   wdata      register write value
//   write      write strobe, effective only with cpu_en
//   rdata      combinational read of the selected register
//   timer_int  registered interrupt request to the interrupt controller
module gb_timer #(
  parameter logic [15:0] DIV_INIT = 16'h0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_en,
  input  logic [1:0] addr,
  input  logic [7:0] wdata,
  input  logic       write,
  output logic [7:0] rdata,
  output logic       timer_int
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_OVF    = 2'd1,
    ST_RELOAD = 2'd2
  } state_t;

  state_t      state_r, state_n;
  logic [15:0] sys_cnt_r, sys_cnt_n;
  logic [7:0]  tima_r, tima_n;
  logic [7:0]  tma_r, tma_n;
  logic [2:0]  tac_r, tac_n;
  logic        prev_sel_r, prev_sel_n;
  logic        timer_int_r, timer_int_n;

  logic        div_wr_s, tima_wr_s, tma_wr_s, tac_wr_s;
  logic        tap_bit_s, sel_s, inc_s;

  assign div_wr_s  = cpu_en & write & (addr == 2'd0);
  assign tima_wr_s = cpu_en & write & (addr == 2'd1);
  assign tma_wr_s  = cpu_en & write & (addr == 2'd2);
  assign tac_wr_s  = cpu_en & write & (addr == 2'd3);

  assign timer_int = timer_int_r;

  // Register read mux; unused TAC bits read back as ones.
  always_comb begin
    rdata = 8'h00;
    case (addr)
      2'd0:    rdata = sys_cnt_r[15:8];
      2'd1:    rdata = tima_r;
      2'd2:    rdata = tma_r;
      2'd3:    rdata = {5'b11111, tac_r};
      default: rdata = 8'h00;
    endcase
  end

  // Next-state logic: counter, registers, tap edge detect and TIMA FSM.
  always_comb begin
    sys_cnt_n   = sys_cnt_r;
    tima_n      = tima_r;
    tma_n       = tma_r;
    tac_n       = tac_r;
    state_n     = state_r;
    prev_sel_n  = prev_sel_r;
    timer_int_n = timer_int_r;
    tap_bit_s   = 1'b0;
    sel_s       = 1'b0;
    inc_s       = 1'b0;

    if (cpu_en) begin
      // A DIV write clears the counter instead of advancing it.
      if (div_wr_s) begin
        sys_cnt_n = 16'h0000;
      end else begin
        sys_cnt_n = sys_cnt_r + 16'd4;
      end

      if (tma_wr_s) begin
        tma_n = wdata;
      end else begin
        tma_n = tma_r;
      end

      if (tac_wr_s) begin
        tac_n = wdata[2:0];
      end else begin
        tac_n = tac_r;
      end

      // The tap is sampled after this cycle's counter and TAC updates, so a
      // write that lowers the select shows up as a falling edge right here.
      case (tac_n[1:0])
        2'd0:    tap_bit_s = sys_cnt_n[9];
        2'd1:    tap_bit_s = sys_cnt_n[3];
        2'd2:    tap_bit_s = sys_cnt_n[5];
        2'd3:    tap_bit_s = sys_cnt_n[7];
        default: tap_bit_s = 1'b0;
      endcase
      sel_s      = tac_n[2] & tap_bit_s;
      prev_sel_n = sel_s;
      inc_s      = prev_sel_r & ~sel_s;
`ifdef GB_TIMER_GLITCH_EN
      inc_s = prev_sel_r & ~sel_s;
`else
      // Without the glitch model, write-induced edges never clock TIMA.
      if (div_wr_s | tac_wr_s) begin
        inc_s = 1'b0;
      end else begin
        inc_s = prev_sel_r & ~sel_s;
      end
`endif

      // The interrupt lasts exactly one cpu_en window.
      timer_int_n = 1'b0;

      case (state_r)
        ST_RUN: begin
          if (tima_wr_s) begin
            tima_n = wdata;
          end else if (inc_s) begin
            if (tima_r == 8'hFF) begin
              tima_n  = 8'h00;
              state_n = ST_OVF;
            end else begin
              tima_n = tima_r + 8'd1;
            end
          end else begin
            tima_n = tima_r;
          end
        end
        ST_OVF: begin
          // A TIMA write here cancels both the reload and the interrupt.
          if (tima_wr_s) begin
            tima_n  = wdata;
            state_n = ST_RUN;
          end else begin
            tima_n      = tma_n;
            timer_int_n = 1'b1;
            state_n     = ST_RELOAD;
          end
        end
        ST_RELOAD: begin
          // TIMA is still being loaded from TMA: TMA writes fall through.
          if (tma_wr_s) begin
            tima_n = wdata;
          end else begin
            tima_n = tima_r;
          end
          state_n = ST_RUN;
        end
        default: begin
          tima_n  = tima_r;
          state_n = ST_RUN;
        end
      endcase
    end else begin
      sys_cnt_n = sys_cnt_r;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sys_cnt_r   <= {DIV_INIT[15:2], 2'b00};
      tima_r      <= 8'h00;
      tma_r       <= 8'h00;
      tac_r       <= 3'b000;
      state_r     <= ST_RUN;
      prev_sel_r  <= 1'b0;
      timer_int_r <= 1'b0;
    end else begin
      sys_cnt_r   <= sys_cnt_n;
      tima_r      <= tima_n;
      tma_r       <= tma_n;
      tac_r       <= tac_n;
      state_r     <= state_n;
      prev_sel_r  <= prev_sel_n;
      timer_int_r <= timer_int_n;
    end
  end

endmodule
